// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//   Shares one bitwise logic unit (AND/OR/XOR/NOR) between two requesters.
//   A three-state controller (IDLE -> EXEC -> DONE) grants the unit
//   round-robin, captures the winner's operands, registers the result and
//   pulses the winner's done for one cycle.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req0/req1      level requests, held until the matching done
//   op0/op1        operation: 00 AND, 01 OR, 10 XOR, 11 NOR
//   a0,b0 / a1,b1  operands, stable while the request is high
//   gnt            one-hot grant (bit i = requester i owns the unit)
//   done0/done1    one-cycle completion pulse
//   result, zero   registered result of the last completed op, result == 0
//   busy           high in EXEC and DONE
// -----------------------------------------------------------------------------

// Existing fixed-width 32-bit AND block, reused for the AND function.
module logic_and32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = a_i & b_i;
endmodule

module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The AND path is built from whole 32-bit blocks; operands are zero-padded
  // up to a multiple of 32 bits and the padding is dropped on the way out.
  localparam int NBLK = (WIDTH + 31) / 32;

  state_t             state_q;
  logic               last_grant_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  logic               pick_d;      // winner index when granting from IDLE
  logic [WIDTH-1:0]   result_d;
  logic [NBLK*32-1:0] a_pad;
  logic [NBLK*32-1:0] b_pad;
  logic [NBLK*32-1:0] and_pad;

  // On a tie the requester that did not win last time gets the unit;
  // otherwise whichever single requester is asserted wins.
  always_comb begin
    pick_d = req1;
    if (req0 && req1) begin
      pick_d = ~last_grant_q;
    end
  end

  always_comb begin
    a_pad = '0;
    b_pad = '0;
    a_pad[WIDTH-1:0] = a_q;
    b_pad[WIDTH-1:0] = b_q;
  end

  generate
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_and
      logic_and32 u_and (
        .a_i (a_pad[gi*32 +: 32]),
        .b_i (b_pad[gi*32 +: 32]),
        .y_o (and_pad[gi*32 +: 32])
      );
    end
  endgenerate

  always_comb begin
    result_d = '0;
    unique case (op_q)
      2'b00: result_d = and_pad[WIDTH-1:0];
      2'b01: result_d = a_q | b_q;
      2'b10: result_d = a_q ^ b_q;
      2'b11: result_d = ~(a_q | b_q);
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      gnt          <= 2'b00;
      done0        <= 1'b0;
      done1        <= 1'b0;
      result       <= '0;
      zero         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            op_q         <= pick_d ? op1 : op0;
            a_q          <= pick_d ? a1  : a0;
            b_q          <= pick_d ? b1  : b0;
            gnt          <= pick_d ? 2'b10 : 2'b01;
            last_grant_q <= pick_d;
            busy         <= 1'b1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          result  <= result_d;
          zero    <= (result_d == '0);
          // done is registered here so it is high exactly during DONE
          done0   <= gnt[0];
          done1   <= gnt[1];
          state_q <= DONE;
        end
        DONE: begin
          gnt     <= 2'b00;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt     <= 2'b00;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
